// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, constants and baud divider helper
package uart_pkg;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_STOP      = 3'd3,
        RX_WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clock cycles per oversample tick; integer truncation is intentional.
    function automatic int baud_div(input int clk_freq, input int baud, input int os);
        return clk_freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - free-running prescaler emitting one tick every DIV cycles
module uart_baud_tick #(
    parameter int DIV = 325
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign tick   = w_wrap;

    // Clear restarts the phase so the first tick lands DIV cycles after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1 receiver delivering bytes as FIFO write strobes
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    input  logic       rx_full,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rx_busy
);

    localparam int DIV = baud_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int TW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS);

    logic                 r_sync1;
    logic                 r_sync2;
    rx_state_t            r_state;
    rx_state_t            w_state_nxt;
    logic [TW-1:0]        r_tcnt;
    logic [BW-1:0]        r_bidx;
    logic [DATA_BITS-1:0] r_sh;
    logic [7:0]           r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_oerr;
    logic                 r_busy;

    logic w_rxd_s;
    logic w_tick;
    logic w_clr;
    logic w_tmid;
    logic w_tlast;
    logic w_blast;
    logic w_sample;
    logic w_stop_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rxd;
            r_sync2 <= r_sync1;
        end
    end

    assign w_rxd_s = r_sync2;
    assign w_clr   = (r_state == RX_IDLE) && !w_rxd_s;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    assign w_tmid     = (r_tcnt == TW'(OVERSAMPLE / 2 - 1));
    assign w_tlast    = (r_tcnt == TW'(OVERSAMPLE - 1));
    assign w_blast    = (r_bidx == BW'(DATA_BITS - 1));
    assign w_sample   = (r_state == RX_DATA) && w_tick && w_tlast;
    assign w_stop_dec = (r_state == RX_STOP) && w_tick && w_tlast;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RX_IDLE:      if (!w_rxd_s) w_state_nxt = RX_START;
            RX_START:     if (w_tick && w_tmid) w_state_nxt = w_rxd_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (w_sample && w_blast) w_state_nxt = RX_STOP;
            RX_STOP:      if (w_stop_dec) w_state_nxt = w_rxd_s ? RX_IDLE : RX_WAIT_HIGH;
            RX_WAIT_HIGH: if (w_rxd_s) w_state_nxt = RX_IDLE;
            default:      w_state_nxt = RX_IDLE;
        endcase
    end

    // Busy is registered from the next state so it tracks the FSM exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RX_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != RX_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tcnt <= '0;
        end else begin
            case (r_state)
                RX_START: if (w_tick) r_tcnt <= w_tmid ? '0 : r_tcnt + TW'(1);
                RX_DATA,
                RX_STOP:  if (w_tick) r_tcnt <= w_tlast ? '0 : r_tcnt + TW'(1);
                default:  r_tcnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bidx <= '0;
            r_sh   <= '0;
        end else begin
            if (r_state == RX_START) begin
                r_bidx <= '0;
            end else if (w_sample && !w_blast) begin
                r_bidx <= r_bidx + BW'(1);
            end
            if (w_sample) begin
                r_sh <= {w_rxd_s, r_sh[DATA_BITS-1:1]};
            end
        end
    end

    // Stop-bit decision: the only cycle in which rx_full is consulted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            r_valid <= w_stop_dec && w_rxd_s && !rx_full;
            r_oerr  <= w_stop_dec && w_rxd_s && rx_full;
            r_ferr  <= w_stop_dec && !w_rxd_s;
            if (w_stop_dec && w_rxd_s && !rx_full) begin
                r_data <= r_sh;
            end
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign frame_err   = r_ferr;
    assign overrun_err = r_oerr;
    assign rx_busy     = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level reference model
module tb_uart_rx;

    localparam int CLK_FREQ = 614_400;
    localparam int BAUD     = 9600;
    localparam int OS       = 16;
    localparam int DIV      = CLK_FREQ / (BAUD * OS);
    localparam int BIT      = OS * DIV;
    localparam int LAT      = (OS / 2 + 9 * OS) * DIV + 3;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       rxd     = 1'b1;
    logic       rx_full = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun_err;
    logic       rx_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    int v_cnt = 0, fe_cnt = 0, ov_cnt = 0, excl_bad = 0, last_v_cyc = 0, c_start = 0;
    logic [7:0] got_q[$];

    int exp_v = 0, exp_fe = 0, exp_ov = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rxd         (rxd),
        .rx_full     (rx_full),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                v_cnt++;
                got_q.push_back(rx_data);
                last_v_cyc = cyc;
            end
            if (frame_err)   fe_cnt++;
            if (overrun_err) ov_cnt++;
            if (int'(rx_valid) + int'(frame_err) + int'(overrun_err) > 1) excl_bad++;
        end
    end

    // Frame-level reference: what a complete frame must produce.
    task automatic model_frame(input logic [7:0] b, input logic stop, input logic full);
        if (!stop) begin
            exp_fe++;
        end else if (full) begin
            exp_ov++;
        end else begin
            exp_v++;
            exp_q.push_back(b);
            exp_data = b;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rxd = v;
        idle(BIT);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_bits);
        c_start = cyc + 1;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        rxd = stop;
        idle(BIT * stop_bits);
        rxd = 1'b1;
    endtask

    task automatic test_reset;
        idle(4);
        rst_n = 1'b1;
        idle(2);
        checks++;
        if (rx_data !== 8'h00) begin
            errors++; $display("FAIL reset_data: got %h want 00", rx_data);
        end
        checks++;
        if ({rx_valid, frame_err, overrun_err, rx_busy} !== 4'b0000) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {rx_valid, frame_err, overrun_err, rx_busy});
        end
    endtask

    task automatic test_single_frame;
        int lat;
        send_frame(8'hA5, 1'b1, 1);
        model_frame(8'hA5, 1'b1, 1'b0);
        idle(BIT);
        checks++;
        if (v_cnt !== exp_v) begin
            errors++; $display("FAIL single_count: got %0d want %0d", v_cnt, exp_v);
        end
        checks++;
        if (rx_data !== 8'hA5) begin
            errors++; $display("FAIL single_data: got %h want a5", rx_data);
        end
        lat = last_v_cyc - c_start + 1;
        checks++;
        if (lat < LAT - 1 || lat > LAT + 1) begin
            errors++; $display("FAIL single_latency: got %0d want %0d +-1", lat, LAT);
        end
        checks++;
        if (fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin
            errors++; $display("FAIL single_errs: got fe=%0d ov=%0d want fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov);
        end
    endtask

    task automatic test_glitch;
        rxd = 1'b0;
        idle(3 * DIV);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++; $display("FAIL glitch_busy_high: got %b want 1", rx_busy);
        end
        rxd = 1'b1;
        idle(BIT);
        checks++;
        if (rx_busy !== 1'b0) begin
            errors++; $display("FAIL glitch_busy_low: got %b want 0", rx_busy);
        end
        checks++;
        if (v_cnt !== exp_v || fe_cnt !== exp_fe || ov_cnt !== exp_ov) begin
            errors++; $display("FAIL glitch_pulses: got v=%0d fe=%0d ov=%0d want v=%0d fe=%0d ov=%0d",
                               v_cnt, fe_cnt, ov_cnt, exp_v, exp_fe, exp_ov);
        end
    endtask

    task automatic test_frame_err;
        send_frame(8'h3C, 1'b0, 2);
        model_frame(8'h3C, 1'b0, 1'b0);
        checks++;
        if (rx_busy !== 1'b1) begin
            errors++; $display("FAIL ferr_wait_busy: got %b want 1", rx_busy);
        end
        idle(BIT);
        checks++;
        if (fe_cnt !== exp_fe || v_cnt !== exp_v) begin
            errors++; $display("FAIL ferr_count: got fe=%0d v=%0d want fe=%0d v=%0d", fe_cnt, v_cnt, exp_fe, exp_v);
        end
        checks++;
        if (rx_data !== exp_data || rx_busy !== 1'b0) begin
            errors++; $display("FAIL ferr_hold: got data=%h busy=%b want data=%h busy=0", rx_data, rx_busy, exp_data);
        end
        send_frame(8'h96, 1'b1, 1);
        model_frame(8'h96, 1'b1, 1'b0);
        idle(BIT);
        checks++;
        if (v_cnt !== exp_v || rx_data !== 8'h96) begin
            errors++; $display("FAIL ferr_recover: got v=%0d data=%h want v=%0d data=96", v_cnt, rx_data, exp_v);
        end
    endtask

    task automatic test_back_to_back;
        int q0;
        q0 = got_q.size();
        send_frame(8'h00, 1'b1, 1);
        model_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1);
        model_frame(8'hFF, 1'b1, 1'b0);
        idle(BIT);
        checks++;
        if (got_q.size() !== q0 + 2) begin
            errors++; $display("FAIL b2b_count: got %0d want %0d", got_q.size() - q0, 2);
        end else begin
            checks++;
            if (got_q[q0] !== 8'h00 || got_q[q0+1] !== 8'hFF) begin
                errors++; $display("FAIL b2b_data: got %h %h want 00 ff", got_q[q0], got_q[q0+1]);
            end
        end
    endtask

    task automatic test_overrun;
        rx_full = 1'b1;
        send_frame(8'h5A, 1'b1, 1);
        rx_full = 1'b0;
        model_frame(8'h5A, 1'b1, 1'b1);
        idle(BIT);
        checks++;
        if (ov_cnt !== exp_ov || v_cnt !== exp_v) begin
            errors++; $display("FAIL ovr_count: got ov=%0d v=%0d want ov=%0d v=%0d", ov_cnt, v_cnt, exp_ov, exp_v);
        end
        checks++;
        if (rx_data !== exp_data) begin
            errors++; $display("FAIL ovr_hold: got %h want %h", rx_data, exp_data);
        end
    endtask

    task automatic test_reset_midframe;
        logic [7:0] b;
        b = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(b[i]);
        rxd = b[4];
        idle(BIT / 2);
        rst_n = 1'b0;
        #1;
        exp_data = 8'h00;
        checks++;
        if (rx_data !== 8'h00 || {rx_valid, frame_err, overrun_err, rx_busy} !== 4'b0000) begin
            errors++; $display("FAIL midrst_outputs: got data=%h flags=%b want 00 0000",
                               rx_data, {rx_valid, frame_err, overrun_err, rx_busy});
        end
        rxd = 1'b1;
        idle(4);
        rst_n = 1'b1;
        idle(2 * BIT);
        checks++;
        if (v_cnt !== exp_v || fe_cnt !== exp_fe || ov_cnt !== exp_ov || rx_busy !== 1'b0) begin
            errors++; $display("FAIL midrst_quiet: got v=%0d fe=%0d ov=%0d busy=%b", v_cnt, fe_cnt, ov_cnt, rx_busy);
        end
        send_frame(b, 1'b1, 1);
        model_frame(b, 1'b1, 1'b0);
        idle(BIT);
        checks++;
        if (v_cnt !== exp_v || rx_data !== 8'h81) begin
            errors++; $display("FAIL midrst_next: got v=%0d data=%h want v=%0d data=81", v_cnt, rx_data, exp_v);
        end
    endtask

    task automatic test_random;
        logic [7:0] b;
        logic       full;
        for (int k = 0; k < 8; k++) begin
            b    = 8'($urandom);
            full = ($urandom_range(0, 3) == 0);
            rx_full = full;
            send_frame(b, 1'b1, 1);
            rx_full = 1'b0;
            model_frame(b, 1'b1, full);
            idle($urandom_range(0, 2 * BIT));
        end
        idle(BIT);
        checks++;
        if (ov_cnt !== exp_ov || fe_cnt !== exp_fe) begin
            errors++; $display("FAIL rand_errs: got ov=%0d fe=%0d want ov=%0d fe=%0d", ov_cnt, fe_cnt, exp_ov, exp_fe);
        end
        checks++;
        if (rx_data !== exp_data) begin
            errors++; $display("FAIL rand_last: got %h want %h", rx_data, exp_data);
        end
    endtask

    task automatic test_stream_totals;
        checks++;
        if (got_q.size() !== exp_q.size()) begin
            errors++; $display("FAIL stream_len: got %0d want %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stream_byte%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (excl_bad !== 0) begin
            errors++; $display("FAIL exclusive_pulses: got %0d overlaps want 0", excl_bad);
        end
    endtask

    initial begin
        test_reset;
        test_single_frame;
        test_glitch;
        test_frame_err;
        test_back_to_back;
        test_overrun;
        test_reset_midframe;
        test_random;
        test_stream_totals;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver front-end for the UART controller: oversamples the asynchronous `rxd` line, validates start bit, recovers 8N1 frames LSB-first and delivers each byte as a one-cycle write strobe into the controller's RX FIFO. Sits directly upstream of the RX FIFO inside `uart_control`; `uart_control` exposes the result through `r_en`/`data_out`/`empty`. Also reports framing and overrun errors.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 9600: line rate in bit/s.
- `OVERSAMPLE`, 16: ticks per bit period; must be even and ≥ 8.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rxd`  in  1  serial input, idle high, asynchronous to `clk`.
- `rx_full`  in  1  RX FIFO full flag from the controller.
- `rx_data`  out  8  last received byte; held between frames.
- `rx_valid`  out  1  one-cycle FIFO write strobe; `rx_data` valid in that cycle.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: good frame dropped because `rx_full` = 1.
- `rx_busy`  out  1  high in any state other than IDLE.

## Operation
- `rxd` passes through a 2-flop synchronizer (both flops reset to 1) → `rxd_s`. Only `rxd_s` is used.
- Prescaler: `DIV = CLK_FREQ/(BAUD*OVERSAMPLE)`, integer truncation (325 at defaults). Counts 0..DIV-1, asserts `tick` for one cycle at DIV-1, wraps to 0. Cleared on IDLE→START.
- Tick counter `tcnt` (0..OVERSAMPLE-1), bit index `bidx` (0..7), shift register `sh[7:0]`.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: `rxd_s` = 0 → START, `tcnt` = 0.
  - START: on tick, `tcnt`++; at `tcnt` = OVERSAMPLE/2-1 tick (mid start bit): `rxd_s` = 0 → DATA, `tcnt` = 0, `bidx` = 0; `rxd_s` = 1 → IDLE (glitch rejected, no outputs).
  - DATA: on tick with `tcnt` = OVERSAMPLE-1: `sh <= {rxd_s, sh[7:1]}`, `tcnt` = 0; after bit 7 → STOP, else `bidx`++.
  - STOP: on tick with `tcnt` = OVERSAMPLE-1 (mid stop bit): `rxd_s` = 1 and `rx_full` = 0 → `rx_data <= sh`, `rx_valid` pulse, → IDLE; `rxd_s` = 1 and `rx_full` = 1 → `overrun_err` pulse, `rx_data` unchanged, → IDLE; `rxd_s` = 0 → `frame_err` pulse, `rx_data` unchanged, → WAIT_HIGH.
  - WAIT_HIGH: stays until `rxd_s` = 1 → IDLE (a break never produces repeated frames).
- Returning to IDLE at mid stop bit leaves half a bit of margin, so back-to-back frames with zero idle gap are received.
- `rx_valid`, `frame_err`, `overrun_err` mutually exclusive; never asserted together.

## Timing
- Reset values: `rx_data` = 8'h00, `rx_valid` = `frame_err` = `overrun_err` = `rx_busy` = 0; FSM IDLE; prescaler, `tcnt`, `bidx`, `sh` = 0.
- Reset mid-frame: immediate return to IDLE, partial byte discarded, no pulse emitted; after release a frame is only accepted from a new falling edge.
- Latency: `rxd` first sampled low at edge 0 → FSM in START after edge 2 → `rx_valid` high for exactly one cycle, (OVERSAMPLE/2 + 9·OVERSAMPLE)·DIV + 3 edges after edge 0 (152·325+3 = 49403 at defaults); bench tolerance ±1 cycle.
- `rx_full` sampled only in the stop-bit decision cycle.
- All outputs registered; no combinational path from `rxd` or `rx_full` to any output.

## Structure
- Shared package `uart_pkg`: `rx_state_t` enum, `DATA_BITS` = 8, function `baud_div(clk_freq, baud, os)`; TX side reuses the same function.
- One sub-module: `uart_baud_tick` (prescaler with synchronous clear, parameter DIV, outputs `tick`); TX instantiates it too.

## Test plan
- Frame 0xA5 at 9600 baud, `rx_full` = 0 → single `rx_valid` pulse, `rx_data` = 0xA5 at cycle 49403 ±1, no error pulses.
- `rxd` low for 3·DIV cycles then high → no `rx_valid`/errors, `rx_busy` drops back to 0 after mid-start check.
- Frame 0x3C with stop bit 0, line held low 2 bit times → one `frame_err`, `rx_data` unchanged, no new frame until `rxd` high and next falling edge.
- Frames 0x00 then 0xFF back-to-back, zero idle → two `rx_valid` pulses, data 0x00 then 0xFF.
- Frame 0x5A with `rx_full` = 1 → `overrun_err` pulse, no `rx_valid`, `rx_data` keeps previous value.
- `rst_n` asserted during bit 4 of 0x81 → outputs at reset values immediately; following frame 0x81 received correctly.
